// File: rtl/stats_dma_pkg.sv
// Shared definitions for the DMA completion statistics block:
// shadow read-map addresses and the fill values of an empty window.
package stats_dma_pkg;

   localparam int unsigned RD_ADDR_WIDTH = 5;

   localparam logic [RD_ADDR_WIDTH-1:0] ADDR_COUNT     = 5'd0;
   localparam logic [RD_ADDR_WIDTH-1:0] ADDR_ERR_COUNT = 5'd1;
   localparam logic [RD_ADDR_WIDTH-1:0] ADDR_BYTE_SUM  = 5'd2;
   localparam logic [RD_ADDR_WIDTH-1:0] ADDR_LAT_SUM   = 5'd3;
   localparam logic [RD_ADDR_WIDTH-1:0] ADDR_LAT_MIN   = 5'd4;
   localparam logic [RD_ADDR_WIDTH-1:0] ADDR_LAT_MAX   = 5'd5;
   localparam logic [RD_ADDR_WIDTH-1:0] ADDR_SNAP_SEQ  = 5'd6;
   localparam logic [RD_ADDR_WIDTH-1:0] ADDR_RESERVED  = 5'd7;
   localparam logic [RD_ADDR_WIDTH-1:0] ADDR_BIN_BASE  = 5'd16;

   // Empty window: lat_min is filled with this bit (all-ones), every other field with the other.
   localparam logic EMPTY_MIN_BIT   = 1'b1;
   localparam logic EMPTY_OTHER_BIT = 1'b0;

endpackage

// File: rtl/stats_sat_acc.sv
// Saturating accumulator: adds inc_val when inc_en, sticks at all-ones, clears to zero.
// next_value exposes the post-increment, pre-clear value so a snapshot can capture it.
module stats_sat_acc #(
   parameter int W  = 32,
   parameter int IW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          inc_en,
   input  logic [IW-1:0] inc_val,
   output logic [W-1:0]  value,
   output logic [W-1:0]  next_value
);

   logic [W:0] sum;

   assign sum = {1'b0, value} + (W+1)'(inc_val);

   always_comb begin
      next_value = value;
      if (inc_en) begin
         next_value = sum[W] ? '1 : sum[W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         value <= '0;
      end else begin
         value <= next_value;
      end
   end

endmodule

// File: rtl/stats_dma_latency_accum.sv
// DMA completion statistics: live accumulators updated per event, a shadow copy taken
// on snapshot, and a one-cycle registered read port over the shadow copy.
module stats_dma_latency_accum
   import stats_dma_pkg::*;
#(
   parameter int COUNT_WIDTH  = 16,
   parameter int TAG_WIDTH    = 8,
   parameter int LEN_WIDTH    = 16,
   parameter int STATUS_WIDTH = 4,
   parameter int ACC_WIDTH    = 32,
   parameter int BIN_SHIFT    = 4,
   parameter int BIN_COUNT    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [TAG_WIDTH-1:0]    in_tag,
   input  logic [LEN_WIDTH-1:0]    in_len,
   input  logic [STATUS_WIDTH-1:0] in_status,
   input  logic [COUNT_WIDTH-1:0]  in_latency,
   input  logic                    in_valid,
   input  logic                    snapshot,
   input  logic                    clear_on_snapshot,
   input  logic [4:0]              rd_addr,
   input  logic                    rd_en,
   output logic [ACC_WIDTH-1:0]    rd_data,
   output logic                    rd_valid
);

   logic                   clear_live;
   logic                   unused_tag;
   logic [ACC_WIDTH-1:0]   count_q, count_d, err_q, err_d;
   logic [ACC_WIDTH-1:0]   bytes_q, bytes_d, lat_sum_q, lat_sum_d;
   logic [ACC_WIDTH-1:0]   bin_q [BIN_COUNT];
   logic [ACC_WIDTH-1:0]   bin_d [BIN_COUNT];
   logic [BIN_COUNT-1:0]   bin_hit;
   logic [COUNT_WIDTH-1:0] lat_bin_raw;
   logic [COUNT_WIDTH-1:0] lat_min_q, lat_min_d, lat_max_q, lat_max_d;
   logic [ACC_WIDTH-1:0]   snap_seq_q, snap_seq_d;

   logic [ACC_WIDTH-1:0]   sh_count, sh_err, sh_bytes, sh_lat_sum, sh_seq;
   logic [COUNT_WIDTH-1:0] sh_min, sh_max;
   logic [ACC_WIDTH-1:0]   sh_bin [BIN_COUNT];
   logic [ACC_WIDTH-1:0]   rd_mux;

   assign clear_live  = snapshot && clear_on_snapshot;
   // The tag carries no statistic; it is only observed.
   assign unused_tag  = ^in_tag;
   assign lat_bin_raw = in_latency >> BIN_SHIFT;
   assign snap_seq_d  = snap_seq_q + 1'b1;

   stats_sat_acc #(.W(ACC_WIDTH), .IW(1)) u_count (
      .clk(clk), .rst(rst), .clear(clear_live), .inc_en(in_valid), .inc_val(1'b1),
      .value(count_q), .next_value(count_d));

   stats_sat_acc #(.W(ACC_WIDTH), .IW(1)) u_err (
      .clk(clk), .rst(rst), .clear(clear_live), .inc_en(in_valid && (in_status != '0)),
      .inc_val(1'b1), .value(err_q), .next_value(err_d));

   stats_sat_acc #(.W(ACC_WIDTH), .IW(LEN_WIDTH)) u_bytes (
      .clk(clk), .rst(rst), .clear(clear_live), .inc_en(in_valid), .inc_val(in_len),
      .value(bytes_q), .next_value(bytes_d));

   stats_sat_acc #(.W(ACC_WIDTH), .IW(COUNT_WIDTH)) u_lat_sum (
      .clk(clk), .rst(rst), .clear(clear_live), .inc_en(in_valid), .inc_val(in_latency),
      .value(lat_sum_q), .next_value(lat_sum_d));

   // The last bin also collects every latency beyond the histogram range.
   for (genvar b = 0; b < BIN_COUNT; b++) begin : g_bin
      if (b == BIN_COUNT - 1) begin : g_last
         assign bin_hit[b] = in_valid && (lat_bin_raw >= COUNT_WIDTH'(b));
      end else begin : g_mid
         assign bin_hit[b] = in_valid && (lat_bin_raw == COUNT_WIDTH'(b));
      end
      stats_sat_acc #(.W(ACC_WIDTH), .IW(1)) u_bin (
         .clk(clk), .rst(rst), .clear(clear_live), .inc_en(bin_hit[b]), .inc_val(1'b1),
         .value(bin_q[b]), .next_value(bin_d[b]));
   end

   always_comb begin
      lat_min_d = lat_min_q;
      lat_max_d = lat_max_q;
      if (in_valid) begin
         if (in_latency <= lat_min_q) lat_min_d = in_latency;
         if (in_latency >= lat_max_q) lat_max_d = in_latency;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_live) begin
         lat_min_q <= {COUNT_WIDTH{EMPTY_MIN_BIT}};
         lat_max_q <= {COUNT_WIDTH{EMPTY_OTHER_BIT}};
      end else begin
         lat_min_q <= lat_min_d;
         lat_max_q <= lat_max_d;
      end
   end

   // The sequence number survives a clearing snapshot; only reset zeroes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_seq_q <= '0;
      end else if (snapshot) begin
         snap_seq_q <= snap_seq_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_count   <= '0;
         sh_err     <= '0;
         sh_bytes   <= '0;
         sh_lat_sum <= '0;
         sh_seq     <= '0;
         sh_min     <= {COUNT_WIDTH{EMPTY_MIN_BIT}};
         sh_max     <= {COUNT_WIDTH{EMPTY_OTHER_BIT}};
         for (int i = 0; i < BIN_COUNT; i++) sh_bin[i] <= '0;
      end else if (snapshot) begin
         sh_count   <= count_d;
         sh_err     <= err_d;
         sh_bytes   <= bytes_d;
         sh_lat_sum <= lat_sum_d;
         sh_seq     <= snap_seq_d;
         sh_min     <= lat_min_d;
         sh_max     <= lat_max_d;
         for (int i = 0; i < BIN_COUNT; i++) sh_bin[i] <= bin_d[i];
      end
   end

   always_comb begin
      rd_mux = '0;
      case (rd_addr)
         ADDR_COUNT:     rd_mux = sh_count;
         ADDR_ERR_COUNT: rd_mux = sh_err;
         ADDR_BYTE_SUM:  rd_mux = sh_bytes;
         ADDR_LAT_SUM:   rd_mux = sh_lat_sum;
         ADDR_LAT_MIN:   rd_mux = ACC_WIDTH'(sh_min);
         ADDR_LAT_MAX:   rd_mux = ACC_WIDTH'(sh_max);
         ADDR_SNAP_SEQ:  rd_mux = sh_seq;
         default:        rd_mux = '0;
      endcase
      for (int i = 0; i < BIN_COUNT; i++) begin
         if (rd_addr == ADDR_BIN_BASE + 5'(i)) rd_mux = sh_bin[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         rd_data  <= rd_en ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_stats_dma_latency_accum.sv
// Bench for stats_dma_latency_accum: a 32-bit and an 8-bit build share one stimulus
// stream and are compared against an arithmetic model of the statistics window.
module tb_stats_dma_latency_accum;

   localparam int NI = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_tag;
   logic [15:0] in_len;
   logic [3:0]  in_status;
   logic [15:0] in_latency;
   logic        in_valid, snapshot, clear_on_snapshot, rd_en;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data_w;
   logic        rd_valid_w;
   logic [7:0]  rd_data_n;
   logic        rd_valid_n;

   int vectors = 0;
   int miscompares = 0;

   // clock / reset
   always #5 clk = ~clk;

   stats_dma_latency_accum dut_w (
      .clk(clk), .rst(rst), .in_tag(in_tag), .in_len(in_len), .in_status(in_status),
      .in_latency(in_latency), .in_valid(in_valid), .snapshot(snapshot),
      .clear_on_snapshot(clear_on_snapshot), .rd_addr(rd_addr), .rd_en(rd_en),
      .rd_data(rd_data_w), .rd_valid(rd_valid_w));

   stats_dma_latency_accum #(
      .COUNT_WIDTH(8), .TAG_WIDTH(8), .LEN_WIDTH(8), .STATUS_WIDTH(4),
      .ACC_WIDTH(8), .BIN_SHIFT(4), .BIN_COUNT(8)
   ) dut_n (
      .clk(clk), .rst(rst), .in_tag(in_tag), .in_len(in_len[7:0]), .in_status(in_status),
      .in_latency(in_latency[7:0]), .in_valid(in_valid), .snapshot(snapshot),
      .clear_on_snapshot(clear_on_snapshot), .rd_addr(rd_addr), .rd_en(rd_en),
      .rd_data(rd_data_n), .rd_valid(rd_valid_n));

   // reference model: true totals, clamped to the accumulator range when captured
   longint cmask [NI];
   longint amask [NI];
   longint m_count [NI], m_err [NI], m_bytes [NI], m_lat [NI];
   longint m_min [NI], m_max [NI], m_seq [NI];
   longint m_bin [NI][8];
   longint m_sh  [NI][32];

   function automatic longint clamp(input longint v, input longint lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_clear_live(input int i);
      m_count[i] = 0; m_err[i] = 0; m_bytes[i] = 0; m_lat[i] = 0;
      m_min[i] = cmask[i]; m_max[i] = 0;
      for (int b = 0; b < 8; b++) m_bin[i][b] = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         model_clear_live(i);
         m_seq[i] = 0;
         for (int a = 0; a < 32; a++) m_sh[i][a] = 0;
         m_sh[i][4] = cmask[i];
      end
   endtask

   task automatic model_event(input int i, input int len, input int st, input int lat);
      longint l, n, b;
      l = longint'(lat) & cmask[i];
      n = longint'(len) & cmask[i];
      m_count[i]++;
      if ((st & 15) != 0) m_err[i]++;
      m_bytes[i] += n;
      m_lat[i] += l;
      if (l < m_min[i]) m_min[i] = l;
      if (l > m_max[i]) m_max[i] = l;
      b = l / 16;
      if (b > 7) b = 7;
      m_bin[i][b]++;
   endtask

   task automatic model_snap(input int i, input bit clr);
      m_seq[i] = (m_seq[i] + 1) & amask[i];
      for (int a = 0; a < 32; a++) m_sh[i][a] = 0;
      m_sh[i][0] = clamp(m_count[i], amask[i]);
      m_sh[i][1] = clamp(m_err[i], amask[i]);
      m_sh[i][2] = clamp(m_bytes[i], amask[i]);
      m_sh[i][3] = clamp(m_lat[i], amask[i]);
      m_sh[i][4] = m_min[i];
      m_sh[i][5] = m_max[i];
      m_sh[i][6] = m_seq[i];
      for (int b = 0; b < 8; b++) m_sh[i][16 + b] = clamp(m_bin[i][b], amask[i]);
      if (clr) model_clear_live(i);
   endtask

   // scoreboard check
   task automatic check(input string tag, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // driver: one clock of stimulus, then model update and read-port check
   task automatic cycle(input bit ev, input int len, input int st, input int lat,
                        input bit snap, input bit clr, input bit rd, input int addr);
      longint exp_w, exp_n;
      exp_w = rd ? m_sh[0][addr] : 0;
      exp_n = rd ? m_sh[1][addr] : 0;
      in_valid = ev; in_len = 16'(len); in_status = 4'(st); in_latency = 16'(lat);
      in_tag = 8'($urandom); snapshot = snap; clear_on_snapshot = clr;
      rd_en = rd; rd_addr = 5'(addr);
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
         exp_w = 0;
         exp_n = 0;
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (ev) model_event(i, len, st, lat);
            if (snap) model_snap(i, clr);
         end
      end
      check("rd_valid_w", longint'(rd_valid_w), longint'(rd && !rst));
      check("rd_valid_n", longint'(rd_valid_n), longint'(rd && !rst));
      check($sformatf("rd_data_w[%0d]", addr), longint'(rd_data_w), exp_w);
      check($sformatf("rd_data_n[%0d]", addr), longint'(rd_data_n), exp_n);
      in_valid = 1'b0; snapshot = 1'b0; clear_on_snapshot = 1'b0; rd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic ev(input int lat, input int len, input int st);
      cycle(1, len, st, lat, 0, 0, 0, 0);
   endtask

   task automatic snap(input bit clr);
      cycle(0, 0, 0, 0, 1, clr, 0, 0);
   endtask

   task automatic read_all();
      for (int a = 0; a < 32; a++) cycle(0, 0, 0, 0, 0, 0, 1, a);
   endtask

   // read with hand-derived constants in addition to the model
   task automatic rd_chk(input string tag, input int addr, input longint exp_w, input longint exp_n);
      cycle(0, 0, 0, 0, 0, 0, 1, addr);
      check({tag, "_w"}, longint'(rd_data_w), exp_w);
      check({tag, "_n"}, longint'(rd_data_n), exp_n);
   endtask

   task automatic do_reset(input bit busy);
      rst = 1'b1;
      cycle(busy, 100, 1, 50, busy, 0, busy, 0);
      rst = 1'b0;
   endtask

   initial begin
      cmask[0] = 64'hFFFF;      amask[0] = 64'hFFFF_FFFF;
      cmask[1] = 64'hFF;        amask[1] = 64'hFF;
      model_reset();
      rst = 1'b1;
      in_valid = 0; snapshot = 0; clear_on_snapshot = 0; rd_en = 0;
      in_len = 0; in_status = 0; in_latency = 0; in_tag = 0; rd_addr = 0;
      do_reset(0);
      do_reset(0);

      // reset contents, then reset dominating events/snapshot/read mid-window
      read_all();
      for (int k = 0; k < 5; k++) ev(10 * k + 3, 32, 0);
      do_reset(1);
      read_all();
      rd_chk("rst_count", 0, 0, 0);
      rd_chk("rst_min", 4, 64'hFFFF, 64'hFF);
      rd_chk("rst_seq", 6, 0, 0);

      // directed window: three events then a non-clearing snapshot
      ev(5, 64, 0);
      ev(20, 128, 0);
      ev(200, 256, 3);
      snap(0);
      rd_chk("count", 0, 3, 3);
      rd_chk("err", 1, 1, 1);
      rd_chk("bytes", 2, 448, 192);
      rd_chk("lat_sum", 3, 225, 225);
      rd_chk("min", 4, 5, 5);
      rd_chk("max", 5, 200, 200);
      rd_chk("bin0", 16, 1, 1);
      rd_chk("bin1", 17, 1, 1);
      rd_chk("bin7", 23, 1, 1);
      rd_chk("addr9", 9, 0, 0);
      read_all();
      // read colliding with snapshot sees the old shadow value
      cycle(1, 8, 0, 7, 1, 0, 1, 0);
      check("rd_snap_old_w", longint'(rd_data_w), 3);
      rd_chk("count_after", 0, 4, 4);

      // clearing snapshot with a simultaneous event, then an empty window
      do_reset(0);
      cycle(1, 16, 0, 10, 1, 1, 0, 0);
      rd_chk("clr_count", 0, 1, 1);
      rd_chk("clr_min", 4, 10, 10);
      snap(0);
      rd_chk("empty_count", 0, 0, 0);
      rd_chk("empty_min", 4, 64'hFFFF, 64'hFF);
      rd_chk("empty_max", 5, 0, 0);
      rd_chk("empty_seq", 6, 2, 2);

      // back-to-back events: narrow build saturates instead of wrapping
      do_reset(0);
      for (int k = 0; k < 1000; k++) ev(16, 1, 0);
      snap(1);
      rd_chk("b2b_count", 0, 1000, 255);
      rd_chk("b2b_bin1", 17, 1000, 255);
      rd_chk("b2b_lat_sum", 3, 16000, 255);
      rd_chk("b2b_bytes", 2, 1000, 255);
      read_all();

      // randomized traffic
      do_reset(0);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset($urandom_range(0, 1) == 1);
         end else begin
            cycle($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 65535)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                              : int'($urandom_range(0, 300)),
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 31)));
         end
      end
      snap(0);
      read_all();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stats_dma_latency_accum.md
STATS_DMA_LATENCY_ACCUM -- requirements
Module: stats_dma_latency_accum

Interface
REQ-001 Parameter COUNT_WIDTH, default 16: width of in_latency.
REQ-002 Parameter TAG_WIDTH, default 8: width of in_tag.
REQ-003 Parameter LEN_WIDTH, default 16: width of in_len.
REQ-004 Parameter STATUS_WIDTH, default 4: width of in_status.
REQ-005 Parameter ACC_WIDTH, default 32: width of every accumulator and rd_data; must be >= COUNT_WIDTH and >= LEN_WIDTH.
REQ-006 Parameter BIN_SHIFT, default 4: log2 of histogram bin width in cycles.
REQ-007 Parameter BIN_COUNT, default 8: number of histogram bins, power of two, 2..16.
REQ-008 clk  in  1  clock; all logic on rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 in_tag  in  TAG_WIDTH  completed-operation tag; ignored except for sampling.
REQ-011 in_len  in  LEN_WIDTH  operation length in bytes.
REQ-012 in_status  in  STATUS_WIDTH  completion status; zero = success.
REQ-013 in_latency  in  COUNT_WIDTH  start-to-finish latency in cycles.
REQ-014 in_valid  in  1  single-cycle event strobe; no backpressure, event accepted every cycle it is high.
REQ-015 snapshot  in  1  pulse: copy live accumulators into shadow set.
REQ-016 clear_on_snapshot  in  1  sampled with snapshot; when high, live set is cleared at the same edge.
REQ-017 rd_addr  in  5  shadow register index.
REQ-018 rd_en  in  1  read strobe.
REQ-019 rd_data  out  ACC_WIDTH  read result.
REQ-020 rd_valid  out  1  high for one cycle with rd_data.

Function
REQ-021 Live set: count, err_count (status != 0), byte_sum (+in_len), lat_sum (+in_latency), lat_min, lat_max, bin[0..BIN_COUNT-1], snap_seq.
REQ-022 Event at edge N updates live set at edge N (zero pipeline latency); result observable from cycle N+1.
REQ-023 Bin index = min(in_latency >> BIN_SHIFT, BIN_COUNT-1); that bin increments by one.
REQ-024 All counters and sums saturate at all-ones; no wrap-around.
REQ-025 Empty live set: lat_min = all-ones (COUNT_WIDTH), lat_max = 0, all others 0.
REQ-026 lat_min/lat_max update with unsigned compare, inclusive of equal values.
REQ-027 On snapshot, shadow <= live including any event at the same edge; snap_seq increments (wrapping, ACC_WIDTH), shadow receives the incremented value.
REQ-028 snapshot with clear_on_snapshot high: live set returns to empty values (REQ-025) after capture; simultaneous event is counted in the snapshot, not the new window; snap_seq not cleared.
REQ-029 snapshot with clear_on_snapshot low: live set continues accumulating.
REQ-030 Read map (shadow only): 0 count, 1 err_count, 2 byte_sum, 3 lat_sum, 4 lat_min, 5 lat_max, 6 snap_seq, 7 reserved (0), 16..16+BIN_COUNT-1 bins; any other address returns 0.
REQ-031 Read latency one cycle: rd_en at edge N -> rd_valid and rd_data at cycle N+1; rd_data is 0 when rd_valid low.
REQ-032 Read simultaneous with snapshot returns pre-snapshot shadow value.
REQ-033 Narrow fields zero-extended to ACC_WIDTH.

Reset
REQ-034 rst clears live set to empty values, shadow set to empty values, snap_seq to 0, rd_valid and rd_data to 0.
REQ-035 rst dominates in_valid, snapshot and rd_en at the same edge; those inputs are discarded.
REQ-036 Reset mid-window loses all accumulated data; no partial snapshot is taken.

Structure
REQ-037 Read-map address constants and empty-value definitions belong in shared package stats_dma_pkg.
REQ-038 One sub-module, stats_sat_acc (saturating add with clear and increment-by-value), instantiated per counter/sum/bin.
REQ-039 Shadow and live sets are flip-flop registers, not RAM; no multicycle paths.

Verification
REQ-040 Events latency 5,20,200 len 64,128,256 status 0,0,3, then snapshot -> count 3, err_count 1, byte_sum 448, lat_sum 225, min 5, max 200, bin0=1, bin1=1, bin7=1.
REQ-041 snapshot with clear and in_valid (latency 10) same cycle -> snapshot count includes it; next snapshot with no events -> count 0, min 0xFFFF, max 0, snap_seq 2.
REQ-042 Preload via 2^ACC_WIDTH-1 style stress (ACC_WIDTH=8 build, 300 events) -> count reads 255, no wrap.
REQ-043 rd_en addr 4 at cycle N -> rd_valid cycle N+1 only; addr 9 -> 0; rd_en with snapshot same cycle -> old value.
REQ-044 rst asserted with in_valid and snapshot after 5 events -> all reads 0 except min 0xFFFF; snap_seq 0.
REQ-045 Back-to-back in_valid every cycle for 1000 cycles latency 16 -> count 1000, bin1=1000, lat_sum 16000.
